// File: rtl/chrono_sequencer_if.sv
// Button/tick inputs and display/status outputs of the chronometer sequencer.
// slave is the sequencer side; master is the driver/observer side.
interface chrono_sequencer_if;
    logic        tick_100hz;
    logic        btn_startstop_p;
    logic        btn_lapreset_p;
    logic [23:0] display;
    logic        running;
    logic        lap_frozen;
    logic [1:0]  state;
    logic        wrap_p;

    modport slave (
        input  tick_100hz, btn_startstop_p, btn_lapreset_p,
        output display, running, lap_frozen, state, wrap_p
    );

    modport master (
        output tick_100hz, btn_startstop_p, btn_lapreset_p,
        input  display, running, lap_frozen, state, wrap_p
    );
endinterface

// File: rtl/chrono_sequencer.sv
// Start/stop/lap chronometer sequencer: owns the mm:ss.cc BCD counter,
// the lap-freeze register and the registered six-digit display word.
//
// state   | meaning
// IDLE    | stopped and cleared, waiting for start
// RUNNING | counting, display live
// PAUSED  | stopped, display shows held time
// LAP     | counting, display frozen at lap capture
module chrono_sequencer #(
    parameter int MIN_MAX = 99
) (
    input  logic                clk_ms,
    input  logic                rst_n,
    chrono_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } state_t;

    localparam logic [3:0] MAX_M1 = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_M0 = 4'(MIN_MAX % 10);

    state_t      st;
    logic [23:0] cnt;
    logic [23:0] lap_reg;
    logic [23:0] cnt_inc;
    logic [23:0] cnt_adv;
    logic        wrap_all;
    logic        counting;
    logic        wrap_hit;

    logic [3:0] m1, m0, s1, s0, c1, c0;
    logic [3:0] n_m1, n_m0, n_s1, n_s0, n_c1, n_c0;

    assign {m1, m0, s1, s0, c1, c0} = cnt;

    // Ripple-carry BCD increment of the whole counter in one cycle.
    always_comb begin
        n_m1 = m1; n_m0 = m0; n_s1 = s1; n_s0 = s0; n_c1 = c1; n_c0 = c0;
        wrap_all = 1'b0;
        if (c0 != 4'd9) begin
            n_c0 = c0 + 4'd1;
        end else begin
            n_c0 = 4'd0;
            if (c1 != 4'd9) begin
                n_c1 = c1 + 4'd1;
            end else begin
                n_c1 = 4'd0;
                if (s0 != 4'd9) begin
                    n_s0 = s0 + 4'd1;
                end else begin
                    n_s0 = 4'd0;
                    if (s1 != 4'd5) begin
                        n_s1 = s1 + 4'd1;
                    end else begin
                        n_s1 = 4'd0;
                        if (m1 == MAX_M1 && m0 == MAX_M0) begin
                            n_m1 = 4'd0;
                            n_m0 = 4'd0;
                            wrap_all = 1'b1;
                        end else if (m0 != 4'd9) begin
                            n_m0 = m0 + 4'd1;
                        end else begin
                            n_m0 = 4'd0;
                            n_m1 = m1 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign cnt_inc  = {n_m1, n_m0, n_s1, n_s0, n_c1, n_c0};
    assign counting = bus.tick_100hz && (st == RUNNING || st == LAP);
    assign cnt_adv  = counting ? cnt_inc : cnt;
    assign wrap_hit = counting && wrap_all;
    assign bus.state = st;

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            st             <= IDLE;
            cnt            <= '0;
            lap_reg        <= '0;
            bus.display    <= '0;
            bus.running    <= 1'b0;
            bus.lap_frozen <= 1'b0;
            bus.wrap_p     <= 1'b0;
        end else begin
            cnt         <= cnt_adv;
            bus.wrap_p  <= wrap_hit;
            bus.display <= cnt_adv;
            // startstop is tested first everywhere so it wins over lapreset
            case (st)
                IDLE: begin
                    if (bus.btn_startstop_p) begin
                        st          <= RUNNING;
                        bus.running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (bus.btn_startstop_p) begin
                        st          <= PAUSED;
                        bus.running <= 1'b0;
                    end else if (bus.btn_lapreset_p) begin
                        st             <= LAP;
                        bus.lap_frozen <= 1'b1;
                        lap_reg        <= cnt;
                        bus.display    <= cnt;
                    end
                end
                LAP: begin
                    if (bus.btn_startstop_p) begin
                        st             <= PAUSED;
                        bus.running    <= 1'b0;
                        bus.lap_frozen <= 1'b0;
                    end else if (bus.btn_lapreset_p) begin
                        st             <= RUNNING;
                        bus.lap_frozen <= 1'b0;
                    end else begin
                        bus.display <= lap_reg;
                    end
                end
                PAUSED: begin
                    if (bus.btn_startstop_p) begin
                        st          <= RUNNING;
                        bus.running <= 1'b1;
                    end else if (bus.btn_lapreset_p) begin
                        st          <= IDLE;
                        cnt         <= '0;
                        bus.display <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chrono_sequencer.sv
// Directed bench for chrono_sequencer (MIN_MAX=1): a per-cycle vector table
// plus hand-written sequences for long-running and reset corner cases.
module tb_chrono_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    chrono_sequencer_if bus ();

    chrono_sequencer #(.MIN_MAX(1)) dut (
        .clk_ms (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ss;
        logic        lr;
        logic        tk;
        logic [23:0] disp;
        logic [1:0]  st;
        logic        wrap;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [23:0] disp, input logic [1:0] st,
                           input logic wrap);
        chk({name, " display"}, 32'(bus.display), 32'(disp));
        chk({name, " state"}, 32'(bus.state), 32'(st));
        chk({name, " running"}, 32'(bus.running), 32'(st == 2'b01 || st == 2'b11));
        chk({name, " lap_frozen"}, 32'(bus.lap_frozen), 32'(st == 2'b11));
        chk({name, " wrap_p"}, 32'(bus.wrap_p), 32'(wrap));
    endtask

    // Drive inputs for one clock edge, return 1 time unit after it.
    task automatic cyc(input logic ss, input logic lr, input logic tk);
        bus.btn_startstop_p = ss;
        bus.btn_lapreset_p  = lr;
        bus.tick_100hz      = tk;
        @(posedge clk);
        #1;
        bus.btn_startstop_p = 1'b0;
        bus.btn_lapreset_p  = 1'b0;
        bus.tick_100hz      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.btn_startstop_p = 1'b0;
        bus.btn_lapreset_p  = 1'b0;
        bus.tick_100hz      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            ss    lr    tk    display    state  wrap
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 24'h000000, 2'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 24'h000001, 2'd1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 24'h000002, 2'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 24'h000002, 2'd3, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 24'h000002, 2'd3, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 24'h000004, 2'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 24'h000004, 2'd3, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 24'h000006, 2'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 24'h000006, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 24'h000006, 2'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 24'h000007, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 24'h000000, 2'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 24'h000000, 2'd0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 24'h000000, 2'd1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 24'h000001, 2'd1, 1'b0};

        bus.btn_startstop_p = 1'b0;
        bus.btn_lapreset_p  = 1'b0;
        bus.tick_100hz      = 1'b0;
        #2;
        chk_all("reset", 24'h0, 2'd0, 1'b0);
        do_reset();
        chk_all("after release", 24'h0, 2'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].ss, vecs[i].lr, vecs[i].tk);
            chk_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].st, vecs[i].wrap);
        end

        // start then 150 ticks
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(150);
        chk_all("start150", 24'h000150, 2'd1, 1'b0);

        // lap freeze and release
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(42);
        cyc(1'b0, 1'b1, 1'b0);
        chk_all("lap entry", 24'h000042, 2'd3, 1'b0);
        ticks(100);
        chk_all("lap hold", 24'h000042, 2'd3, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_all("lap exit", 24'h000142, 2'd1, 1'b0);

        // pause, ticks ignored, then clear
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(507);
        chk_all("pre pause", 24'h000507, 2'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        ticks(50);
        chk_all("paused hold", 24'h000507, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_all("clear", 24'h000000, 2'd0, 1'b0);

        // wrap at 01:59.99 with MIN_MAX=1, passing 00:59.99 -> 01:00.00 on the way
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(5999);
        chk_all("pre minute", 24'h005999, 2'd1, 1'b0);
        ticks(1);
        chk_all("minute carry", 24'h010000, 2'd1, 1'b0);
        ticks(5999);
        chk_all("pre wrap", 24'h015999, 2'd1, 1'b0);
        ticks(1);
        chk_all("wrap", 24'h000000, 2'd1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk_all("post wrap", 24'h000000, 2'd1, 1'b0);
        ticks(1);
        chk_all("post wrap tick", 24'h000001, 2'd1, 1'b0);

        // async reset between edges while in LAP
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b1, 1'b1);
        chk_all("lap before rst", 24'h000003, 2'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 24'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_all("idle after rst", 24'h0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/chrono_sequencer.md
# chrono_sequencer

Control block for the start/stop chronometer with reset and lap. It takes debounced single-cycle button pulses and a 100 Hz tick strobe, and runs a four-state sequencer. The sequencer owns the centisecond/second/minute BCD time counter and the lap-freeze register, and presents a six-digit display word. It sits between the improved toggle pushbuttons and the display driver, all in the 50 MHz master-clock domain.

## Interface
Parameters:
- MIN_MAX, default 99: highest minute value before the counter wraps; legal range 1..99.

Ports:
- clk_ms  in  1  master clock, 50 MHz; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_100hz  in  1  single-cycle strobe at 100 Hz, synchronous to clk_ms.
- btn_startstop_p  in  1  single-cycle debounced press pulse, start/stop.
- btn_lapreset_p  in  1  single-cycle debounced press pulse, lap/reset.
- display  out  24  BCD digits {m1,m0,s1,s0,c1,c0}, 4 bits each.
- running  out  1  high in RUNNING and LAP.
- lap_frozen  out  1  high in LAP.
- state  out  2  IDLE=00, RUNNING=01, PAUSED=10, LAP=11.
- wrap_p  out  1  single-cycle pulse when the counter wraps from MIN_MAX:59:99 to 00:00:00.

## Operation
- Internal time counter: BCD cc 00..99, ss 00..59, mm 00..MIN_MAX.
  - Increments by 1 cs on a cycle where tick_100hz=1 and the current (pre-edge) state is RUNNING or LAP.
  - Carries ripple within the same cycle. Every digit stays 0..9 at all times.
- Lap register: 24 bits. Loads the current (pre-increment) counter value on entry to LAP.
- display = lap register while in LAP; otherwise the live counter.
- State transitions (on pulses):
  - IDLE: startstop -> RUNNING. lapreset is ignored.
  - RUNNING: startstop -> PAUSED. lapreset -> LAP and captures the lap register.
  - LAP: lapreset -> RUNNING, and the display goes live again. startstop -> PAUSED, and the display goes live, showing the stopped time.
  - PAUSED: startstop -> RUNNING. lapreset -> IDLE and clears the counter to 0.
- Both pulses in the same cycle: startstop takes priority and lapreset is discarded.
- A pulse with no matching transition is dropped. Pulses are never queued.
- Counter wrap: MIN_MAX:59:99 + tick -> 00:00:00. wrap_p=1 for that one cycle and the state is unchanged.

## Timing
- Reset (async assert, synchronous release):
  - state=IDLE, counter=0, lap register=0.
  - display=24'h000000, running=0, lap_frozen=0, wrap_p=0.
- All outputs are registered.
  - A pulse at edge N is reflected in state, running, lap_frozen and display after edge N.
  - Latency is 1 clk_ms cycle.
- Tick in the same cycle as a transition: the increment follows the pre-edge state.
  - IDLE->RUNNING with a tick: no increment.
  - RUNNING->PAUSED with a tick: increments.
  - RUNNING->LAP with a tick: the counter increments, and the lap register gets the pre-increment value.
- PAUSED->IDLE: the clear takes effect at the same edge. No tick can apply because the pre-edge state is not counting.
- rst_n asserted mid-run: all registers clear immediately, with no wait for the clock. After release the block waits in IDLE.
- Throughput: one transition per cycle. Back-to-back pulses on consecutive cycles are each honoured.

## Test plan
- Reset and start:
  - Stimulus: release reset, startstop pulse, then 150 ticks.
  - Required: display=24'h000150 (00:01.50), state=01, running=1.
- Lap freeze:
  - Stimulus: at 00:00.42, lapreset pulse, then 100 ticks.
  - Required: display holds 24'h000042 and lap_frozen=1.
  - Then a second lapreset pulse. Required: display=24'h000142, state=01.
- Pause and clear:
  - Stimulus: running at 00:05.07, startstop pulse, 50 ticks, then lapreset pulse.
  - Required: display stays 24'h000507 during the ticks, state=10. After lapreset: display=0, state=00.
- Simultaneous events:
  - Stimulus: in RUNNING, both pulses and a tick on the same cycle.
  - Required: state=10, counter incremented by 1, lap_frozen=0.
- Wrap (MIN_MAX=1):
  - Stimulus: preload to 01:59.99 by ticking, then one tick.
  - Required: display=0, wrap_p high for exactly 1 cycle, state=01.
- Async reset mid-LAP:
  - Stimulus: assert rst_n=0 between clock edges while in LAP.
  - Required: outputs are 0 and state=00 before the next edge.
